// File: rtl/branch_feedback_queue.sv
// In-flight conditional-branch queue: records fetch-time predictions and feeds
// them back to the predictor, in order, once EX resolves each branch.
package mips_core_pkg;
  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;
endpackage

module branch_feedback_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pred_valid,
  input  logic [ADDR_WIDTH-1:0]             pred_pc,
  input  mips_core_pkg::BranchOutcome       pred_outcome,
  output logic                              pred_ready,
  input  logic                              res_valid,
  input  logic [ADDR_WIDTH-1:0]             res_pc,
  input  mips_core_pkg::BranchOutcome       res_outcome,
  input  logic                              flush,
  output logic                              o_fb_valid,
  output logic [ADDR_WIDTH-1:0]             o_fb_pc,
  output mips_core_pkg::BranchOutcome       o_fb_prediction,
  output mips_core_pkg::BranchOutcome       o_fb_outcome,
  output logic                              o_mispredict,
  output logic                              o_error,
  output logic [$clog2(DEPTH+1)-1:0]        o_count
);
  import mips_core_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    BranchOutcome          pred;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head_entry;
  logic [PTR_W-1:0]   head, tail, head_n, tail_n;
  logic [CNT_W-1:0]   count, count_n;
  logic               push, pop, miss, clear, err_set;

  // Ready looks only at the registered count, so a full queue drops a push
  // even when a pop frees a slot on the same edge.
  assign pred_ready = (count < CNT_W'(DEPTH));
  assign o_count    = count;

  // Next-state: a mispredict or flush collapses the queue onto the new head.
  always_comb begin
    head_entry = mem[head];
    pop        = res_valid && (count != '0);
    miss       = pop && (head_entry.pred != res_outcome);
    clear      = flush || miss;
    push       = pred_valid && pred_ready && !clear;
    err_set    = (res_valid && (count == '0)) ||
                 (pop && (res_pc != head_entry.pc));
    head_n     = pop ? head + PTR_W'(1) : head;
    tail_n     = tail;
    count_n    = count;
    if (clear) begin
      tail_n  = head_n;
      count_n = '0;
    end else begin
      if (push) tail_n = tail + PTR_W'(1);
      count_n = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage carries no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail].pc   <= pred_pc;
      mem[tail].pred <= pred_outcome;
    end
  end

  // Pointers, count and registered feedback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      o_fb_valid      <= 1'b0;
      o_fb_pc         <= '0;
      o_fb_prediction <= NOT_TAKEN;
      o_fb_outcome    <= NOT_TAKEN;
      o_mispredict    <= 1'b0;
      o_error         <= 1'b0;
    end else begin
      head         <= head_n;
      tail         <= tail_n;
      count        <= count_n;
      o_fb_valid   <= pop;
      o_mispredict <= miss;
      o_error      <= o_error | err_set;
      if (pop) begin
        o_fb_pc         <= head_entry.pc;
        o_fb_prediction <= head_entry.pred;
        o_fb_outcome    <= res_outcome;
      end
    end
  end

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Directed bench for branch_feedback_queue: a vector table for the basic flow
// plus hand-written sequences for full, mispredict, flush, wrap and reset cases.
module tb_branch_feedback_queue;
  import mips_core_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned CW    = 4;

  logic            clk, rst;
  logic            pred_valid, pred_ready, res_valid, flush;
  logic [AW-1:0]   pred_pc, res_pc, o_fb_pc;
  BranchOutcome    pred_outcome, res_outcome, o_fb_prediction, o_fb_outcome;
  logic            o_fb_valid, o_mispredict, o_error;
  logic [CW-1:0]   o_count;

  branch_feedback_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_outcome(pred_outcome),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_outcome(res_outcome),
    .flush(flush),
    .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc),
    .o_fb_prediction(o_fb_prediction), .o_fb_outcome(o_fb_outcome),
    .o_mispredict(o_mispredict), .o_error(o_error), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         pv;
    logic [31:0]  ppc;
    BranchOutcome po;
    logic         rv;
    logic [31:0]  rpc;
    BranchOutcome ro;
    logic         fl;
    logic         efv;
    logic [31:0]  epc;
    BranchOutcome epred;
    BranchOutcome eout;
    logic         emp;
    logic         eerr;
    logic [3:0]   ecnt;
    logic         erdy;
  } vec_t;

  function automatic vec_t mk(input logic pv, input logic [31:0] ppc, input BranchOutcome po,
                              input logic rv, input logic [31:0] rpc, input BranchOutcome ro,
                              input logic fl, input logic efv, input logic [31:0] epc,
                              input BranchOutcome epred, input BranchOutcome eout,
                              input logic emp, input logic eerr, input logic [3:0] ecnt,
                              input logic erdy);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.po = po; v.rv = rv; v.rpc = rpc; v.ro = ro; v.fl = fl;
    v.efv = efv; v.epc = epc; v.epred = epred; v.eout = eout; v.emp = emp;
    v.eerr = eerr; v.ecnt = ecnt; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] ppc, input BranchOutcome po,
                       input logic rv, input logic [31:0] rpc, input BranchOutcome ro,
                       input logic fl);
    pred_valid = pv; pred_pc = ppc; pred_outcome = po;
    res_valid = rv; res_pc = rpc; res_outcome = ro; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, NOT_TAKEN, 1'b0, 32'h0, NOT_TAKEN, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input BranchOutcome o);
    drive(1'b1, pc, o, 1'b0, 32'h0, NOT_TAKEN, 1'b0);
    tick();
    idle();
  endtask

  task automatic resolve(input logic [31:0] pc, input BranchOutcome o);
    drive(1'b0, 32'h0, NOT_TAKEN, 1'b1, pc, o, 1'b0);
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  vec_t        vecs [10];
  logic [31:0] q [$];
  logic [31:0] exp_pc;
  logic [31:0] next_pc;

  initial begin
    vecs[0] = mk(1, 32'h100, TAKEN,     0, 32'h0,   NOT_TAKEN, 0, 0, 32'h0,   NOT_TAKEN, NOT_TAKEN, 0, 0, 1, 1);
    vecs[1] = mk(1, 32'h104, NOT_TAKEN, 0, 32'h0,   NOT_TAKEN, 0, 0, 32'h0,   NOT_TAKEN, NOT_TAKEN, 0, 0, 2, 1);
    vecs[2] = mk(0, 32'h0,   NOT_TAKEN, 1, 32'h100, TAKEN,     0, 1, 32'h100, TAKEN,     TAKEN,     0, 0, 1, 1);
    vecs[3] = mk(0, 32'h0,   NOT_TAKEN, 0, 32'h0,   NOT_TAKEN, 0, 0, 32'h100, TAKEN,     TAKEN,     0, 0, 1, 1);
    vecs[4] = mk(1, 32'h108, TAKEN,     1, 32'h104, TAKEN,     0, 1, 32'h104, NOT_TAKEN, TAKEN,     1, 0, 0, 1);
    vecs[5] = mk(0, 32'h0,   NOT_TAKEN, 0, 32'h0,   NOT_TAKEN, 0, 0, 32'h104, NOT_TAKEN, TAKEN,     0, 0, 0, 1);
    vecs[6] = mk(1, 32'h200, NOT_TAKEN, 0, 32'h0,   NOT_TAKEN, 0, 0, 32'h104, NOT_TAKEN, TAKEN,     0, 0, 1, 1);
    vecs[7] = mk(1, 32'h204, TAKEN,     1, 32'h200, NOT_TAKEN, 0, 1, 32'h200, NOT_TAKEN, NOT_TAKEN, 0, 0, 1, 1);
    vecs[8] = mk(0, 32'h0,   NOT_TAKEN, 1, 32'h999, TAKEN,     0, 1, 32'h204, TAKEN,     TAKEN,     0, 1, 0, 1);
    vecs[9] = mk(0, 32'h0,   NOT_TAKEN, 1, 32'h0,   TAKEN,     0, 0, 32'h204, TAKEN,     TAKEN,     0, 1, 0, 1);

    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_fb_valid", o_fb_valid, 0);
    chk("rst_fb_pc", o_fb_pc, 0);
    chk("rst_fb_pred", o_fb_prediction, NOT_TAKEN);
    chk("rst_fb_out", o_fb_outcome, NOT_TAKEN);
    chk("rst_mispredict", o_mispredict, 0);
    chk("rst_error", o_error, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ready", pred_ready, 1);
    rst = 1'b0;

    // Vector table: basic push/pop, hold, mispredict, pc mismatch, empty pop.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].pv, vecs[i].ppc, vecs[i].po, vecs[i].rv, vecs[i].rpc, vecs[i].ro, vecs[i].fl);
      tick();
      chk($sformatf("vec%0d_fb_valid", i), o_fb_valid, vecs[i].efv);
      chk($sformatf("vec%0d_fb_pc", i), o_fb_pc, vecs[i].epc);
      chk($sformatf("vec%0d_fb_pred", i), o_fb_prediction, vecs[i].epred);
      chk($sformatf("vec%0d_fb_out", i), o_fb_outcome, vecs[i].eout);
      chk($sformatf("vec%0d_mispredict", i), o_mispredict, vecs[i].emp);
      chk($sformatf("vec%0d_error", i), o_error, vecs[i].eerr);
      chk($sformatf("vec%0d_count", i), o_count, vecs[i].ecnt);
      chk($sformatf("vec%0d_ready", i), pred_ready, vecs[i].erdy);
    end
    idle();
    tick();
    chk("err_sticky", o_error, 1);

    // Full queue: the push coinciding with a pop is dropped.
    do_reset();
    chk("full_err_cleared", o_error, 0);
    for (int i = 0; i < 8; i++) push(32'h1000 + 32'(4 * i), TAKEN);
    chk("full_count", o_count, 8);
    chk("full_ready", pred_ready, 0);
    drive(1'b1, 32'h2000, TAKEN, 1'b1, 32'h1000, TAKEN, 1'b0);
    #1;
    chk("full_ready_pre", pred_ready, 0);
    tick();
    idle();
    chk("full_pop_count", o_count, 7);
    chk("full_pop_fb_valid", o_fb_valid, 1);
    chk("full_pop_fb_pc", o_fb_pc, 32'h1000);
    for (int i = 1; i < 8; i++) begin
      resolve(32'h1000 + 32'(4 * i), TAKEN);
      chk($sformatf("full_drain%0d_pc", i), o_fb_pc, 32'h1000 + 32'(4 * i));
    end
    chk("full_drain_count", o_count, 0);
    chk("full_drain_err", o_error, 0);
    resolve(32'h2000, TAKEN);
    chk("empty_fb_valid", o_fb_valid, 0);
    chk("empty_err", o_error, 1);
    tick();
    tick();
    chk("empty_err_sticky", o_error, 1);
    chk("empty_fb_valid_hold", o_fb_valid, 0);

    // Mispredict collapses the queue; the next push lands at the new head.
    do_reset();
    push(32'h300, TAKEN);
    push(32'h304, TAKEN);
    push(32'h308, TAKEN);
    resolve(32'h300, NOT_TAKEN);
    chk("miss_mp", o_mispredict, 1);
    chk("miss_count", o_count, 0);
    chk("miss_fb_pc", o_fb_pc, 32'h300);
    tick();
    chk("miss_mp_clear", o_mispredict, 0);
    push(32'h400, NOT_TAKEN);
    chk("miss_repush_count", o_count, 1);
    resolve(32'h400, NOT_TAKEN);
    chk("miss_repush_pc", o_fb_pc, 32'h400);
    chk("miss_repush_mp", o_mispredict, 0);
    chk("miss_repush_err", o_error, 0);

    // Flush alone, then flush together with a pop and a push.
    push(32'h500, TAKEN);
    push(32'h504, NOT_TAKEN);
    drive(1'b1, 32'h50C, TAKEN, 1'b0, 32'h0, NOT_TAKEN, 1'b1);
    tick();
    idle();
    chk("flush_count", o_count, 0);
    chk("flush_fb_valid", o_fb_valid, 0);
    push(32'h600, TAKEN);
    push(32'h604, TAKEN);
    drive(1'b1, 32'h608, TAKEN, 1'b1, 32'h600, TAKEN, 1'b1);
    tick();
    idle();
    chk("flushpop_fb_valid", o_fb_valid, 1);
    chk("flushpop_fb_pc", o_fb_pc, 32'h600);
    chk("flushpop_count", o_count, 0);
    push(32'h700, NOT_TAKEN);
    resolve(32'h700, NOT_TAKEN);
    chk("postflush_pc", o_fb_pc, 32'h700);
    chk("postflush_err", o_error, 0);

    // Wrap: 20 simultaneous push/pop pairs on top of 4 queued entries.
    do_reset();
    q.delete();
    next_pc = 32'h8000;
    for (int i = 0; i < 4; i++) begin
      push(next_pc, TAKEN);
      q.push_back(next_pc);
      next_pc += 32'h4;
    end
    for (int i = 0; i < 20; i++) begin
      exp_pc = q.pop_front();
      drive(1'b1, next_pc, TAKEN, 1'b1, exp_pc, TAKEN, 1'b0);
      q.push_back(next_pc);
      next_pc += 32'h4;
      tick();
      idle();
      chk($sformatf("wrap%0d_pc", i), o_fb_pc, exp_pc);
      chk($sformatf("wrap%0d_count", i), o_count, 4);
    end
    while (q.size() > 0) begin
      exp_pc = q.pop_front();
      resolve(exp_pc, TAKEN);
      chk("wrap_drain_pc", o_fb_pc, exp_pc);
      chk("wrap_drain_valid", o_fb_valid, 1);
    end
    chk("wrap_err", o_error, 0);
    chk("wrap_count_end", o_count, 0);

    // Reset arriving with a pop pending: no feedback after release.
    push(32'h900, TAKEN);
    drive(1'b0, 32'h0, NOT_TAKEN, 1'b1, 32'h900, TAKEN, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_count", o_count, 0);
    tick();
    idle();
    rst = 1'b0;
    tick();
    chk("midrst_fb_valid", o_fb_valid, 0);
    chk("midrst_fb_pc", o_fb_pc, 0);
    chk("midrst_err", o_error, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_feedback_queue.md
BRANCH_FEEDBACK_QUEUE -- requirements
Module: branch_feedback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the number of in-flight branch entries; it must be a power of two and at least 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, giving the PC width.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 pred_valid  input  1  fetch has issued a conditional-branch prediction this cycle.
REQ-006 pred_pc  input  ADDR_WIDTH  PC of the predicted branch.
REQ-007 pred_outcome  input  mips_core_pkg::BranchOutcome  direction predicted at fetch.
REQ-008 pred_ready  output  1  queue can accept a push (count < DEPTH).
REQ-009 res_valid  input  1  EX has resolved the oldest in-flight branch.
REQ-010 res_pc  input  ADDR_WIDTH  PC of the resolved branch.
REQ-011 res_outcome  input  mips_core_pkg::BranchOutcome  actual direction.
REQ-012 flush  input  1  pipeline flush; all in-flight entries are discarded.
REQ-013 o_fb_valid  output  1  feedback strobe to the predictor's feedback port.
REQ-014 o_fb_pc  output  ADDR_WIDTH  PC of the branch being fed back.
REQ-015 o_fb_prediction  output  BranchOutcome  recorded prediction.
REQ-016 o_fb_outcome  output  BranchOutcome  resolved outcome.
REQ-017 o_mispredict  output  1  fed-back branch was mispredicted.
REQ-018 o_error  output  1  sticky protocol-error flag.
REQ-019 o_count  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-020 Storage SHALL be a circular buffer of DEPTH entries {pc, prediction}, with head and tail pointers that wrap modulo DEPTH and a separate count register.
REQ-021 A push SHALL occur when pred_valid && pred_ready; the entry is written at tail, and tail and count increment.
REQ-022 pred_ready SHALL derive from the registered count only; a push when count==DEPTH is dropped even if a pop occurs in the same cycle.
REQ-023 A pop SHALL occur when res_valid && count>0; the head entry is read, then head advances and count decrements.
REQ-024 A push and a pop in the same cycle (not full) SHALL leave count unchanged.
REQ-025 Feedback SHALL be registered with a one-cycle latency: the cycle after a pop, o_fb_valid=1 for exactly one cycle.
REQ-026 In that feedback cycle, o_fb_pc and o_fb_prediction SHALL carry the popped entry, and o_fb_outcome SHALL carry res_outcome.
REQ-027 o_mispredict SHALL equal (prediction != res_outcome) and SHALL be asserted only while o_fb_valid is asserted.
REQ-028 When o_fb_valid=0, the o_fb_* fields SHALL hold their previous values.
REQ-029 A mispredicting pop SHALL discard all younger entries in the same edge: count becomes 0, tail is set to the new head, and any simultaneous push is dropped.
REQ-030 flush SHALL clear the queue in the same manner; a simultaneous valid pop is still fed back, and a simultaneous push is dropped.
REQ-031 res_valid while count==0 SHALL produce no feedback and SHALL set o_error.
REQ-032 A pop with res_pc != head pc SHALL set o_error; the feedback is still emitted using the stored pc.
REQ-033 o_error SHALL be sticky until reset.
REQ-034 o_count SHALL reflect the registered count.

Reset
REQ-035 While rst is asserted, the block SHALL force head=0, tail=0, count=0, o_fb_valid=0, o_mispredict=0, o_error=0, o_fb_pc=0, and o_fb_prediction=o_fb_outcome=NOT_TAKEN.
REQ-036 When rst is asserted mid-operation, pending feedback SHALL be cancelled and SHALL NOT be emitted after reset release.
REQ-037 Entry storage does not need to be reset.

Verification
REQ-038 Push pc 0x100 (TAKEN) and pc 0x104 (NOT_TAKEN), then resolve 0x100 TAKEN -> next cycle o_fb_valid=1, o_fb_pc=0x100, o_mispredict=0, o_count=1.
REQ-039 Push 8 entries, then assert pred_valid with res_valid in the same cycle -> 9th push dropped, pred_ready=0, o_count=7.
REQ-040 Push 3 entries, then resolve the head as mispredicted -> o_mispredict=1, o_count=0, and a later push lands at the new head.
REQ-041 res_valid with the queue empty -> o_fb_valid stays 0 and o_error=1 persists until rst.
REQ-042 Resolve with the wrong res_pc -> o_error=1, and o_fb_pc equals the stored pc.
REQ-043 Run 20 push/pop pairs with DEPTH=8 -> pointers wrap, the feedback order matches the push order, and o_count never exceeds 8.
